uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_BITS, default 8, byte width; must match the UART.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum bytes per grant (1..255).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_vld  input  NUM_REQ  per-requester byte valid.
REQ-007 SHALL have port req_last  input  NUM_REQ  per-requester last byte of packet, qualified by req_vld.
REQ-008 SHALL have port req_data  input  NUM_REQ*DATA_BITS  requester i byte at bits [i*DATA_BITS +: DATA_BITS].
REQ-009 SHALL have port req_rdy  output  NUM_REQ  per-requester byte accept.
REQ-010 SHALL have port tx_rdy  input  1  UART transmitter idle.
REQ-011 SHALL have port tx_vld  output  1  byte offered to UART, registered.
REQ-012 SHALL have port tx_data  output  DATA_BITS  byte to UART, registered.
REQ-013 SHALL have port grant_id  output  $clog2(NUM_REQ)  current or last grantee, registered.
REQ-014 SHALL have port busy  output  1  high while state is XFER, registered.

Function
REQ-015 SHALL implement FSM states ARB and XFER.
REQ-016 In ARB with any req_vld high, SHALL pick the first requester with req_vld high, searching from rr_ptr upward with wrap-around; load grant_id, clear byte_cnt, go to XFER on the next edge.
REQ-017 In ARB with no req_vld, SHALL stay in ARB; grant_id unchanged.
REQ-018 req_rdy[i] SHALL be combinational: state==XFER && i==grant_id && tx_rdy && !tx_vld; all other bits 0.
REQ-019 Accept (req_vld[g] && req_rdy[g]) SHALL register tx_data<=req_data[g], tx_vld<=1, byte_cnt<=byte_cnt+1.
REQ-020 tx_vld SHALL clear on the edge after any cycle with tx_vld && tx_rdy; tx_data SHALL hold until the next accept.
REQ-021 Accept with req_last[g]=1, or with byte_cnt==MAX_BURST-1, SHALL return to ARB and set rr_ptr<=(g+1) mod NUM_REQ.
REQ-022 While granted and req_vld[g]=0, SHALL hold the grant; packets are atomic, with no timeout.
REQ-023 A new grant SHALL be allowed while the previous tx_vld handoff is pending; its req_rdy waits for !tx_vld && tx_rdy.
REQ-024 Latency SHALL be: req_vld rising in ARB at cycle 0 gives busy=1 at cycle 1; first accept at cycle 1 if tx_rdy=1; tx_vld=1 at cycle 2.
REQ-025 Requests from non-granted requesters SHALL be ignored, never lost; they are reconsidered in ARB.
REQ-026 byte_cnt SHALL be $clog2(MAX_BURST+1) bits and never wrap (bounded by REQ-021).

Reset
REQ-027 reset SHALL force state=ARB, rr_ptr=0, grant_id=0, byte_cnt=0, tx_vld=0, tx_data=0, busy=0, req_rdy=0.
REQ-028 reset mid-packet SHALL drop the pending byte (tx_vld=0) and the grant; arbitration restarts from requester 0.

Structure
REQ-029 Shared package uart_pkg SHALL hold the DATA_BITS default and the arbiter state enum type.
REQ-030 Priority search SHALL be a combinational sub-module rr_pick (inputs req mask and rr_ptr; outputs index and found).

Verification
REQ-031 Requester 2 only, 3-byte packet 0x41,0x42,0x43 (last on 0x43), tx_rdy model 10-cycle frame -> UART sees 0x41,0x42,0x43 in order; grant_id=2; ARB after third accept; rr_ptr=3.
REQ-032 All 4 requesters hold 1-byte packets from reset -> grant order 0,1,2,3; no req_rdy to non-grantee.
REQ-033 Requester 1 streams 20 bytes with no req_last, MAX_BURST=16, requester 3 waiting -> 16 bytes from 1, then grant to 3, then 1 resumes.
REQ-034 Grantee 0 drops req_vld for 50 cycles mid-packet while requester 1 waits -> grant stays 0, req_rdy[1]=0, tx_vld=0 throughout.
REQ-035 reset asserted one cycle after accept with tx_vld=1 -> next cycle tx_vld=0, busy=0, grant_id=0, req_rdy=0.
REQ-036 tx_rdy held low 100 cycles with the grant active -> no accept; tx_vld stays at its prior value; data is not duplicated.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: default byte width and
// the arbiter state type.
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    XFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART handshake bundle for the transmit arbiter. The slave side is
// the arbiter; the master side is the requesters plus the UART.
interface uart_tx_arbiter_if import uart_pkg::*; #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = DATA_BITS_DEF
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_vld;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_rdy;
  logic                         tx_rdy;
  logic                         tx_vld;
  logic [DATA_BITS-1:0]         tx_data;
  logic [IW-1:0]                grant_id;
  logic                         busy;

  modport master (
    output req_vld, req_last, req_data, tx_rdy,
    input  req_rdy, tx_vld, tx_data, grant_id, busy
  );

  modport slave (
    input  req_vld, req_last, req_data, tx_rdy,
    output req_rdy, tx_vld, tx_data, grant_id, busy
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin priority search: first set bit of req at or above ptr, with
// wrap-around. Purely combinational.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      idx,
  output logic               found
);

  logic [IW-1:0] cand_s;

  // Walk candidates ptr, ptr+1, ... and latch the first requesting one.
  always_comb begin
    idx    = ptr;
    found  = 1'b0;
    cand_s = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s = IW'((int'(ptr) + k) % NUM_REQ);
      idx    = (!found && req[cand_s]) ? cand_s : idx;
      found  = found | req[cand_s];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from NUM_REQ byte streams;
// a grant lasts for a whole packet or MAX_BURST bytes, whichever ends first.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int MAX_BURST = 16
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e           state_r;
  arb_state_e           next_state_s;
  logic [IW-1:0]        rr_ptr_r;
  logic [IW-1:0]        grant_id_r;
  logic [IW-1:0]        pick_idx_s;
  logic                 pick_found_s;
  logic [CW-1:0]        byte_cnt_r;
  logic                 tx_vld_r;
  logic [DATA_BITS-1:0] tx_data_r;
  logic                 busy_r;
  logic [DATA_BITS-1:0] grant_data_s;
  logic [NUM_REQ-1:0]   req_rdy_s;
  logic                 rdy_ok_s;
  logic                 accept_s;
  logic                 end_pkt_s;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req   (bus.req_vld),
    .ptr   (rr_ptr_r),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Grantee handshake, burst termination and next-state decode.
  always_comb begin
    rdy_ok_s               = (state_r == XFER) && bus.tx_rdy && !tx_vld_r;
    req_rdy_s              = {NUM_REQ{1'b0}};
    req_rdy_s[grant_id_r]  = rdy_ok_s;
    grant_data_s           = bus.req_data[int'(grant_id_r)*DATA_BITS +: DATA_BITS];
    accept_s               = bus.req_vld[grant_id_r] && rdy_ok_s;
    // The burst cap is checked before the increment, so byte_cnt never exceeds MAX_BURST.
    end_pkt_s              = accept_s &&
                             (bus.req_last[grant_id_r] || (byte_cnt_r == CW'(MAX_BURST - 1)));
    next_state_s           = state_r;
    case (state_r)
      ARB: begin
        if (pick_found_s) begin
          next_state_s = XFER;
        end else begin
          next_state_s = ARB;
        end
      end
      XFER: begin
        if (end_pkt_s) begin
          next_state_s = ARB;
        end else begin
          next_state_s = XFER;
        end
      end
      default: next_state_s = ARB;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ARB;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Grant, burst counter, round-robin pointer and UART output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r   <= {IW{1'b0}};
      grant_id_r <= {IW{1'b0}};
      byte_cnt_r <= {CW{1'b0}};
      tx_vld_r   <= 1'b0;
      tx_data_r  <= {DATA_BITS{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      if ((state_r == ARB) && pick_found_s) begin
        grant_id_r <= pick_idx_s;
        byte_cnt_r <= {CW{1'b0}};
      end
      // Accept only happens with tx_vld low, so it never collides with the clear.
      if (accept_s) begin
        tx_data_r  <= grant_data_s;
        tx_vld_r   <= 1'b1;
        byte_cnt_r <= byte_cnt_r + CW'(1);
      end else if (tx_vld_r && bus.tx_rdy) begin
        tx_vld_r <= 1'b0;
      end
      if (end_pkt_s) begin
        rr_ptr_r <= (grant_id_r == IW'(NUM_REQ - 1)) ? {IW{1'b0}} : grant_id_r + IW'(1);
      end
      busy_r <= (next_state_s == XFER);
    end
  end

  assign bus.req_rdy  = req_rdy_s;
  assign bus.tx_vld   = tx_vld_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.grant_id = grant_id_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle table for the basic packet flow
// plus hand-written sequences for bursts, stalls and mid-packet reset.
module tb_uart_tx_arbiter;

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  last;
    logic [31:0] data;
    logic        tx_rdy;
    logic [3:0]  e_rdy;
    logic        e_vld;
    logic [7:0]  e_data;
    logic [1:0]  e_gnt;
    logic        e_busy;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_BITS(8)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .MAX_BURST(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         tests = 0;
  int         fails = 0;
  vec_t       vecs[16];
  logic [3:0] vld_v;
  logic [3:0] last_v;
  logic [7:0] byte_v[4];
  int         cnt[4];
  int         log_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    bus.req_vld  = vld_v;
    bus.req_last = last_v;
    bus.req_data = {byte_v[3], byte_v[2], byte_v[1], byte_v[0]};
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    vld_v      = 4'b0000;
    last_v     = 4'b0000;
    for (int i = 0; i < 4; i++) byte_v[i] = 8'h00;
    bus.tx_rdy = 1'b1;
    drive();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Free-running requesters with tx_rdy high; logs the grantee of every accept.
  task automatic run_log(input int n_exp, input int max_cyc);
    logic [3:0] acc;
    logic [7:0] b;
    int         who;
    log_q.delete();
    for (int c = 0; c < max_cyc && log_q.size() < n_exp; c++) begin
      for (int i = 0; i < 4; i++) byte_v[i] = {i[3:0], cnt[i][3:0]};
      drive();
      #1;
      chk("rdy_grantee_only", {28'd0, bus.req_rdy & ~(4'b0001 << bus.grant_id)}, 32'd0);
      acc = bus.req_rdy & vld_v;
      who = -1;
      b   = 8'h00;
      for (int i = 0; i < 4; i++) if (acc[i]) who = i;
      if (who >= 0) begin
        log_q.push_back(who);
        b = byte_v[who];
        cnt[who]++;
        if (last_v[who]) vld_v[who] = 1'b0;
      end
      tick();
      if (who >= 0) chk("burst_tx_data", {24'd0, bus.tx_data}, {24'd0, b});
    end
    chk("accept_count", log_q.size(), n_exp);
  endtask

  initial begin
    int exp032[4];
    int exp033[19];

    vecs[0]  = '{4'b0100, 4'b0000, 32'hD341B1A0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd2, 1'b1};
    vecs[1]  = '{4'b0100, 4'b0000, 32'hD341B1A0, 1'b1, 4'b0100, 1'b1, 8'h41, 2'd2, 1'b1};
    vecs[2]  = '{4'b0100, 4'b0000, 32'hD342B1A0, 1'b1, 4'b0000, 1'b0, 8'h41, 2'd2, 1'b1};
    vecs[3]  = '{4'b0100, 4'b0000, 32'hD342B1A0, 1'b0, 4'b0000, 1'b0, 8'h41, 2'd2, 1'b1};
    vecs[4]  = '{4'b0100, 4'b0000, 32'hD342B1A0, 1'b1, 4'b0100, 1'b1, 8'h42, 2'd2, 1'b1};
    vecs[5]  = '{4'b0100, 4'b0100, 32'hD343B1A0, 1'b0, 4'b0000, 1'b1, 8'h42, 2'd2, 1'b1};
    vecs[6]  = '{4'b0100, 4'b0100, 32'hD343B1A0, 1'b1, 4'b0000, 1'b0, 8'h42, 2'd2, 1'b1};
    vecs[7]  = '{4'b0100, 4'b0100, 32'hD343B1A0, 1'b1, 4'b0100, 1'b1, 8'h43, 2'd2, 1'b0};
    vecs[8]  = '{4'b1011, 4'b0000, 32'hD300B1A0, 1'b1, 4'b0000, 1'b0, 8'h43, 2'd3, 1'b1};
    vecs[9]  = '{4'b1011, 4'b1000, 32'hD300B1A0, 1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3, 1'b0};
    vecs[10] = '{4'b0011, 4'b0011, 32'hD300B1A0, 1'b1, 4'b0000, 1'b0, 8'hD3, 2'd0, 1'b1};
    vecs[11] = '{4'b0011, 4'b0011, 32'hD300B1A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b0};
    vecs[12] = '{4'b0010, 4'b0010, 32'hD300B1A0, 1'b1, 4'b0000, 1'b0, 8'hA0, 2'd1, 1'b1};
    vecs[13] = '{4'b0010, 4'b0010, 32'hD300B1A0, 1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1, 1'b0};
    vecs[14] = '{4'b0000, 4'b0000, 32'hD300B1A0, 1'b1, 4'b0000, 1'b0, 8'hB1, 2'd1, 1'b0};
    vecs[15] = '{4'b0000, 4'b0000, 32'hD300B1A0, 1'b1, 4'b0000, 1'b0, 8'hB1, 2'd1, 1'b0};

    exp032 = '{0, 1, 2, 3};
    for (int i = 0; i < 16; i++) exp033[i] = 1;
    exp033[16] = 3;
    exp033[17] = 1;
    exp033[18] = 1;

    // Reset state
    do_reset();
    chk("rst_tx_vld", {31'd0, bus.tx_vld}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("rst_grant", {30'd0, bus.grant_id}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_rdy", {28'd0, bus.req_rdy}, 32'd0);

    // Table: 3-byte packet from requester 2, then round-robin from rr_ptr=3
    for (int i = 0; i < 16; i++) begin
      bus.req_vld  = vecs[i].vld;
      bus.req_last = vecs[i].last;
      bus.req_data = vecs[i].data;
      bus.tx_rdy   = vecs[i].tx_rdy;
      #1;
      chk($sformatf("v%0d_rdy", i), {28'd0, bus.req_rdy}, {28'd0, vecs[i].e_rdy});
      tick();
      chk($sformatf("v%0d_tx_vld", i), {31'd0, bus.tx_vld}, {31'd0, vecs[i].e_vld});
      chk($sformatf("v%0d_tx_data", i), {24'd0, bus.tx_data}, {24'd0, vecs[i].e_data});
      chk($sformatf("v%0d_grant", i), {30'd0, bus.grant_id}, {30'd0, vecs[i].e_gnt});
      chk($sformatf("v%0d_busy", i), {31'd0, bus.busy}, {31'd0, vecs[i].e_busy});
    end

    // All four requesters with 1-byte packets from reset: order 0,1,2,3
    do_reset();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    vld_v  = 4'b1111;
    last_v = 4'b1111;
    run_log(4, 100);
    for (int i = 0; i < 4 && i < log_q.size(); i++) chk("rr_order", log_q[i], exp032[i]);

    // Requester 1 streams without last, requester 3 waits: burst cap of 16
    do_reset();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    vld_v  = 4'b1010;
    last_v = 4'b1000;
    run_log(19, 400);
    for (int i = 0; i < 19 && i < log_q.size(); i++) chk("burst_order", log_q[i], exp033[i]);

    // Grantee 0 stalls mid-packet while requester 1 waits
    do_reset();
    vld_v     = 4'b0001;
    byte_v[0] = 8'h10;
    drive();
    tick();
    chk("stall_grant0", {30'd0, bus.grant_id}, 32'd0);
    tick();
    chk("stall_first_byte", {23'd0, bus.tx_vld, bus.tx_data}, {23'd0, 1'b1, 8'h10});
    vld_v     = 4'b0010;
    byte_v[1] = 8'h20;
    drive();
    for (int c = 0; c < 50; c++) begin
      tick();
      chk("stall_grant", {30'd0, bus.grant_id}, 32'd0);
      chk("stall_busy", {31'd0, bus.busy}, 32'd1);
      chk("stall_tx_vld", {31'd0, bus.tx_vld}, 32'd0);
      chk("stall_rdy1", {31'd0, bus.req_rdy[1]}, 32'd0);
    end
    vld_v     = 4'b0011;
    last_v    = 4'b0001;
    byte_v[0] = 8'h11;
    drive();
    #1;
    chk("resume_rdy", {28'd0, bus.req_rdy}, 32'h1);
    tick();
    chk("resume_byte", {23'd0, bus.tx_vld, bus.tx_data}, {23'd0, 1'b1, 8'h11});
    chk("resume_busy", {31'd0, bus.busy}, 32'd0);
    vld_v  = 4'b0010;
    last_v = 4'b0000;
    drive();
    tick();
    chk("handoff_grant1", {30'd0, bus.grant_id}, 32'd1);

    // UART busy for 100 cycles with a byte pending: no accept, no duplicate
    byte_v[1] = 8'h55;
    drive();
    #1;
    chk("g1_rdy", {28'd0, bus.req_rdy}, 32'h2);
    tick();
    chk("g1_first", {23'd0, bus.tx_vld, bus.tx_data}, {23'd0, 1'b1, 8'h55});
    bus.tx_rdy = 1'b0;
    byte_v[1]  = 8'h66;
    drive();
    for (int c = 0; c < 100; c++) begin
      tick();
      chk("txstall_vld_data", {23'd0, bus.tx_vld, bus.tx_data}, {23'd0, 1'b1, 8'h55});
      chk("txstall_rdy", {28'd0, bus.req_rdy}, 32'd0);
    end
    bus.tx_rdy = 1'b1;
    tick();
    chk("txstall_release", {23'd0, bus.tx_vld, bus.tx_data}, {23'd0, 1'b0, 8'h55});
    last_v = 4'b0010;
    drive();
    tick();
    chk("txstall_next", {23'd0, bus.tx_vld, bus.tx_data}, {23'd0, 1'b1, 8'h66});
    chk("txstall_done", {31'd0, bus.busy}, 32'd0);

    // Reset one cycle after an accept, with rr_ptr left at 2
    vld_v     = 4'b0100;
    last_v    = 4'b0000;
    byte_v[2] = 8'h77;
    drive();
    tick();
    chk("pre_rst_grant", {30'd0, bus.grant_id}, 32'd2);
    tick();
    chk("pre_rst_byte", {23'd0, bus.tx_vld, bus.tx_data}, {23'd0, 1'b1, 8'h77});
    reset = 1'b1;
    tick();
    chk("mid_rst_tx_vld", {31'd0, bus.tx_vld}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_grant", {30'd0, bus.grant_id}, 32'd0);
    chk("mid_rst_rdy", {28'd0, bus.req_rdy}, 32'd0);
    reset  = 1'b0;
    vld_v  = 4'b0101;
    last_v = 4'b0101;
    drive();
    tick();
    chk("post_rst_grant", {30'd0, bus.grant_id}, 32'd0);
    chk("post_rst_busy", {31'd0, bus.busy}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
